// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit
//   Pipelined ripple-chunk adder/subtractor. A WIDTH-bit add (or a-b as
//   a+~b+1) is split into STAGES = WIDTH/CHUNK slices. Each pipeline stage
//   adds one CHUNK-bit slice and registers the carry into the next stage,
//   so the critical path is one CHUNK-bit adder regardless of WIDTH.
//   The whole pipe advances together under a single valid/ready stall.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake (in_ready = pipe can advance)
//   a, b, c_in, sub       operands; sub=1 selects a-b and ignores c_in
//   out_valid / out_ready output handshake
//   sum, c_out, ovf       result, carry out of MSB, signed overflow
module adder_pipe_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Whole-pipe stall: nothing moves while a result waits on downstream.
  logic w_advance;

  // Stage k consumes the lowest CHUNK bits of the operand bits still
  // outstanding and forwards only the higher, unprocessed bits. Partial
  // sums grow by one slice per stage, so every stored bit is used later.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = WIDTH - k * CHUNK;

    logic                   w_vin;
    logic [RW-1:0]          w_rem_a;
    logic [RW-1:0]          w_rem_b;
    logic                   w_ci;
    logic [CHUNK:0]         w_sl;
    logic [(k+1)*CHUNK-1:0] w_psum_next;

    logic                   r_valid;
    logic [(k+1)*CHUNK-1:0] r_psum;
    logic                   r_cy;

    if (k == 0) begin : g_in
      assign w_vin       = in_valid;
      assign w_rem_a     = a;
      // Subtraction inverts b on capture and forces the carry-in to 1.
      assign w_rem_b     = sub ? ~b : b;
      assign w_ci        = sub | c_in;
      assign w_psum_next = w_sl[CHUNK-1:0];
    end else begin : g_link
      assign w_vin       = g_stage[k-1].r_valid;
      assign w_rem_a     = g_stage[k-1].g_fwd.r_rem_a;
      assign w_rem_b     = g_stage[k-1].g_fwd.r_rem_b;
      assign w_ci        = g_stage[k-1].r_cy;
      assign w_psum_next = {w_sl[CHUNK-1:0], g_stage[k-1].r_psum};
    end

    assign w_sl = {1'b0, w_rem_a[CHUNK-1:0]}
                + {1'b0, w_rem_b[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, w_ci};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_psum  <= '0;
        r_cy    <= 1'b0;
      end else if (w_advance) begin
        r_valid <= w_vin;
        // Bubbles move through as valid=0 but leave the data untouched.
        if (w_vin) begin
          r_psum <= w_psum_next;
          r_cy   <= w_sl[CHUNK];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-CHUNK-1:0] r_rem_a;
      logic [RW-CHUNK-1:0] r_rem_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rem_a <= '0;
          r_rem_b <= '0;
        end else if (w_advance && w_vin) begin
          r_rem_a <= w_rem_a[RW-1:CHUNK];
          r_rem_b <= w_rem_b[RW-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_ovf;

      // The carry into the MSB is a^b^s at that bit; XOR with the carry
      // out of the MSB gives signed overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance && w_vin) begin
          r_ovf <= w_rem_a[CHUNK-1] ^ w_rem_b[CHUNK-1]
                 ^ w_sl[CHUNK-1] ^ w_sl[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_psum;
  assign c_out     = g_stage[STAGES-1].r_cy;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit (WIDTH=8, CHUNK=4, two stages).
module tb_adder_pipe_nbit;

  localparam int     W      = 8;
  localparam int     STAGES = 2;
  localparam longint FULL   = 256;
  localparam longint HALF   = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_pipe_nbit #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference result {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    longint ua, ub, tot, sa, sb, sres;
    logic [W-1:0] s;
    logic c, o;
    ua = longint'(ma);
    ub = longint'(mb);
    if (msub) tot = ua + (FULL - 1 - ub) + 1;
    else      tot = ua + ub + longint'(mcin);
    s  = tot[W-1:0];
    c  = tot[W];
    sa = (ua >= HALF) ? ua - FULL : ua;
    sb = (ub >= HALF) ? ub - FULL : ub;
    sres = msub ? (sa - sb) : (sa + sb + longint'(mcin));
    o = (sres > HALF - 1) || (sres < -HALF);
    return {o, c, s};
  endfunction

  // Scoreboard: each accepted beat carries the number of advancing cycles
  // left before it must show up at the output.
  typedef struct {
    logic [W+1:0] exp;
    int           rem;
  } beat_t;

  beat_t q[$];

  always @(negedge clk) begin : chk
    logic  exp_v;
    logic  adv;
    beat_t nb;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_v = (q.size() > 0) && (q[0].rem == 0);
      check("sb_out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        check("sb_sum",   32'(sum),   32'(q[0].exp[W-1:0]));
        check("sb_c_out", 32'(c_out), 32'(q[0].exp[W]));
        check("sb_ovf",   32'(ovf),   32'(q[0].exp[W+1]));
      end
      adv = !exp_v || out_ready;
      check("sb_in_ready", 32'(in_ready), 32'(adv));
      if (exp_v && out_ready) void'(q.pop_front());
      if (adv) begin
        foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
      end
      if (in_valid && adv) begin
        nb.exp = model(a, b, c_in, sub);
        nb.rem = STAGES - 1;
        q.push_back(nb);
      end
    end
  end

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic ordy);
    @(posedge clk); #1;
    in_valid  = v;
    a         = ta;
    b         = tb;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Single beat into an empty pipe; result expected STAGES cycles later.
  task automatic op1(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                     input logic tsub, input logic [W+1:0] texp, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb; c_in = tcin; sub = tsub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); c_in = 1'b1; sub = 1'b1;
    @(negedge clk);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    repeat (STAGES - 1) @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result"}, 32'({ovf, c_out, sum}), 32'(texp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench completion required");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_c_out",     32'(c_out),     32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the reference model to hand-computed values
    check("model_7f_p_01", 32'(model(8'h7F, 8'h01, 1'b0, 1'b0)), 32'h280);
    check("model_80_m_01", 32'(model(8'h80, 8'h01, 1'b0, 1'b1)), 32'h37F);
    check("model_05_m_07", 32'(model(8'h05, 8'h07, 1'b1, 1'b1)), 32'h0FE);
    check("model_ff_p_01", 32'(model(8'hFF, 8'h01, 1'b0, 1'b0)), 32'h100);

    // Directed single beats {ovf, c_out, sum}
    op1(8'h02, 8'h02, 1'b0, 1'b0, 10'h004, "add_02_02");
    op1(8'hFF, 8'h01, 1'b0, 1'b0, 10'h100, "add_ff_01");
    op1(8'h7F, 8'h01, 1'b0, 1'b0, 10'h280, "add_7f_01");
    op1(8'h0F, 8'h01, 1'b0, 1'b0, 10'h010, "add_0f_01");
    op1(8'h10, 8'h20, 1'b1, 1'b0, 10'h031, "add_cin");
    op1(8'h80, 8'h80, 1'b0, 1'b0, 10'h300, "add_80_80");
    op1(8'h05, 8'h07, 1'b1, 1'b1, 10'h0FE, "sub_05_07");
    op1(8'h80, 8'h01, 1'b0, 1'b1, 10'h37F, "sub_80_01");

    // Streaming: four back-to-back beats, results on consecutive cycles
    for (int i = 0; i < 4 + STAGES; i++) begin
      step(i < 4, 8'(i + 1), 8'(i + 1), 1'b1);
      if (i >= STAGES) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_sum",   32'(sum),       32'(2 * (i - STAGES + 1)));
      end else begin
        check("stream_idle", 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: two beats in flight, three stalled cycles
    step(1'b1, 8'h11, 8'h22, 1'b1);
    check("bp_fill0", 32'(out_valid), 32'd0);
    step(1'b1, 8'h40, 8'h05, 1'b1);
    check("bp_fill1", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hAA, 8'h55, 1'b0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum",   32'(sum),       32'h33);
      check("bp_in_ready",   32'(in_ready),  32'd0);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("bp_rel_valid0", 32'(out_valid), 32'd1);
    check("bp_rel_sum0",   32'(sum),       32'h33);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("bp_rel_valid1", 32'(out_valid), 32'd1);
    check("bp_rel_sum1",   32'(sum),       32'h45);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with two beats in flight
    step(1'b1, 8'h01, 8'h02, 1'b1);
    step(1'b1, 8'h03, 8'h04, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_sum",   32'(sum),       32'h03);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",   32'(sum),       32'd0);
    check("mid_rst_c_out", 32'(c_out),     32'd0);
    check("mid_rst_ovf",   32'(ovf),       32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    op1(8'h10, 8'h20, 1'b0, 1'b0, 10'h030, "post_rst");
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
